// File: rtl/imm_encoder.sv
// Packs a signed immediate into instruction bits [31:7] for I/S/B/U/J, merged with caller fields.
// Latency 2 cycles, 1 beat/cycle, 2-beat capacity; in_ready drops only when both stages are held.
// Backpressure: output held stable while out_valid && !out_ready. Option: IMMENC_SAT_EN clamps out-of-range values.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          imm_val,
    input  logic [2:0]           imm_ctrl,
    input  logic [24:0]          field_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          immed_out,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    logic        s1_valid;
    logic [19:0] s1_imm;
    logic [2:0]  s1_ctrl;
    logic [24:0] s1_field;
    logic        s1_err;

    logic adv1, adv2;
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    logic        small_fmt, big_fmt, fmt_ok;
    logic        fits12, fits20, in_range, range_err, in_err;
    logic [19:0] imm_adj;

    always_comb begin
        small_fmt = (imm_ctrl == FMT_I) || (imm_ctrl == FMT_S) || (imm_ctrl == FMT_B);
        big_fmt   = (imm_ctrl == FMT_U) || (imm_ctrl == FMT_J);
        fmt_ok    = small_fmt || big_fmt;
        // A value fits when every bit above the field's sign bit replicates it.
        fits12    = (&imm_val[31:11]) || !(|imm_val[31:11]);
        fits20    = (&imm_val[31:19]) || !(|imm_val[31:19]);
        in_range  = small_fmt ? fits12 : (big_fmt ? fits20 : 1'b1);
        range_err = fmt_ok && !in_range;
        in_err    = !fmt_ok || range_err;
        imm_adj   = imm_val[19:0];
`ifdef IMMENC_SAT_EN
        if (range_err) begin
            if (small_fmt)
                imm_adj = imm_val[31] ? 20'h00800 : 20'h007FF;
            else
                imm_adj = imm_val[31] ? 20'h80000 : 20'h7FFFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_ctrl  <= '0;
            s1_field <= '0;
            s1_err   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_imm   <= imm_adj;
                s1_ctrl  <= imm_ctrl;
                s1_field <= field_in;
                s1_err   <= in_err;
            end
        end
    end

    logic [24:0] packed_imm;

    always_comb begin
        packed_imm = s1_field;
        case (s1_ctrl)
            FMT_I: packed_imm[24:13] = s1_imm[11:0];
            FMT_S: begin
                packed_imm[24:18] = s1_imm[11:5];
                packed_imm[4:0]   = s1_imm[4:0];
            end
            FMT_B: begin
                packed_imm[24]    = s1_imm[11];
                packed_imm[0]     = s1_imm[10];
                packed_imm[23:18] = s1_imm[9:4];
                packed_imm[4:1]   = s1_imm[3:0];
            end
            FMT_U: packed_imm[24:5] = s1_imm[19:0];
            FMT_J: begin
                packed_imm[24]    = s1_imm[19];
                packed_imm[12:5]  = s1_imm[18:11];
                packed_imm[13]    = s1_imm[10];
                packed_imm[23:14] = s1_imm[9:0];
            end
            default: packed_imm = s1_field;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            immed_out <= '0;
            out_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                immed_out <= packed_imm;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (out_valid && out_ready && out_err && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: inputs driven and outputs checked on the falling clock edge.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm_val;
    logic [2:0]  imm_ctrl;
    logic [24:0] field_in;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] immed_out;
    logic        out_err;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_val   (imm_val),
        .imm_ctrl  (imm_ctrl),
        .field_in  (field_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .immed_out (immed_out),
        .out_err   (out_err),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] imm, input logic [24:0] f);
        in_valid = v;
        imm_ctrl = c;
        imm_val  = imm;
        field_in = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] u_exp;
`ifdef IMMENC_SAT_EN
        u_exp = 32'h0FFFFE0;
`else
        u_exp = 32'h1000000;
`endif
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_immed_out", {7'd0, immed_out}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // I format, two-cycle latency
        drive(1'b1, 3'd0, 32'hFFFFFFFF, 25'd0);
        chk("i_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("i_lat1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("i_valid", {31'd0, out_valid}, 32'd1);
        chk("i_data", {7'd0, immed_out}, 32'h1FFE000);
        chk("i_err", {31'd0, out_err}, 32'd0);
        tick();
        chk("i_drained", {31'd0, out_valid}, 32'd0);

        // S then B back to back
        drive(1'b1, 3'd1, 32'd2047, 25'd0);
        tick();
        drive(1'b1, 3'd2, 32'hFFFFF800, 25'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("s_valid", {31'd0, out_valid}, 32'd1);
        chk("s_data", {7'd0, immed_out}, 32'h0FC001F);
        tick();
        chk("b_valid", {31'd0, out_valid}, 32'd1);
        chk("b_data", {7'd0, immed_out}, 32'h1000000);
        chk("b_err", {31'd0, out_err}, 32'd0);

        // J then invalid format
        drive(1'b1, 3'd4, 32'd1, 25'h000001F);
        tick();
        drive(1'b1, 3'd6, 32'd0, 25'h0ABCDEF);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("j_data", {7'd0, immed_out}, 32'h000401F);
        chk("j_err", {31'd0, out_err}, 32'd0);
        tick();
        chk("inv_valid", {31'd0, out_valid}, 32'd1);
        chk("inv_data", {7'd0, immed_out}, 32'h0ABCDEF);
        chk("inv_err", {31'd0, out_err}, 32'd1);
        chk("inv_cnt_before", {24'd0, err_count}, 32'd0);
        tick();
        chk("inv_cnt_after", {24'd0, err_count}, 32'd1);

        // U out of range
        drive(1'b1, 3'd3, 32'h00080000, 25'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        tick();
        chk("u_oor_data", {7'd0, immed_out}, u_exp);
        chk("u_oor_err", {31'd0, out_err}, 32'd1);
        tick();
        chk("u_oor_cnt", {24'd0, err_count}, 32'd2);

        // Backpressure: exactly two beats absorbed, output held stable
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd1, 25'd0);
        chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 3'd0, 32'd2, 25'd0);
        tick();
        drive(1'b1, 3'd0, 32'd3, 25'd0);
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data0", {7'd0, immed_out}, 32'h0002000);
        tick();
        chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data", {7'd0, immed_out}, 32'h0002000);
        tick();
        chk("bp_hold_data2", {7'd0, immed_out}, 32'h0002000);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drain2", {7'd0, immed_out}, 32'h0004000);
        chk("bp_drain2_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 3'd0, 32'd4, 25'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("bp_drain3", {7'd0, immed_out}, 32'h0006000);
        tick();
        chk("bp_drain4", {7'd0, immed_out}, 32'h0008000);
        chk("bp_drain4_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two beats buffered
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd7, 25'd0);
        tick();
        drive(1'b1, 3'd0, 32'd8, 25'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("mr_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_err_count", {24'd0, err_count}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'd9, 25'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 25'd0);
        chk("mr_no_stale", {31'd0, out_valid}, 32'd0);
        tick();
        chk("mr_new_valid", {31'd0, out_valid}, 32'd1);
        chk("mr_new_data", {7'd0, immed_out}, 32'h0012000);
        tick();
        chk("mr_end_empty", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
